ram_byte_fifo_ctrl: RTL and testbench

//  Byte-stream FIFO controller built around the 4-byte-wide dual-port RAM (dual_ram).

---
 rtl/ram_byte_fifo_ctrl_if.sv | 34 +++
 rtl/ram_byte_fifo_ctrl.sv | 103 ++++++++++
 tb/tb_ram_byte_fifo_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_byte_fifo_ctrl_if.sv
// Signal bundle between the byte FIFO controller, its byte/word stream peers and dual_ram.
// slave is the controller's view; master is the view of whatever surrounds it.
interface ram_byte_fifo_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [4*DW-1:0]   out_data;
    logic              ram_wen;
    logic [AW-1:0]     ram_w_addr;
    logic [4*DW-1:0]   ram_w_data;
    logic              ram_ren;
    logic [AW-1:0]     ram_r_addr;
    logic [4*DW-1:0]   ram_r_data;
    logic [AW-2:0]     word_count;
    logic              fifo_full;
    logic              fifo_empty;

    modport slave (
        input  in_valid, in_data, out_ready, ram_r_data,
        output in_ready, out_valid, out_data, ram_wen, ram_w_addr, ram_w_data,
               ram_ren, ram_r_addr, word_count, fifo_full, fifo_empty
    );

    modport master (
        output in_valid, in_data, out_ready, ram_r_data,
        input  in_ready, out_valid, out_data, ram_wen, ram_w_addr, ram_w_data,
               ram_ren, ram_r_addr, word_count, fifo_full, fifo_empty
    );
endinterface

// File: rtl/ram_byte_fifo_ctrl.sv
// Byte-stream FIFO: packs bytes little-endian into 32-bit words, stores them in a
// circular buffer in dual_ram and streams them back out in order on a valid/ready port.
module ram_byte_fifo_ctrl #(
    parameter int DW      = 8,
    parameter int AW      = 7,
    parameter int MEM_NUM = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_byte_fifo_ctrl_if.slave   bus
);
    localparam int DEPTH = MEM_NUM / 4;
    localparam int PW    = AW - 2;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [AW-2:0] WC_ONE    = (AW-1)'(1);
    localparam logic [AW-2:0] WC_DEPTH  = (AW-1)'(DEPTH);
    localparam logic [AW-1:0] OCC_DEPTH = AW'(DEPTH);

    logic [1:0]      r_byte_cnt;
    logic [3*DW-1:0] r_pack;
    logic [4*DW-1:0] r_w_data;
    logic            r_wr_pend;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [AW-2:0]   r_word_count;
    logic            r_rd_inflight;
    logic            r_out_valid;
    logic [4*DW-1:0] r_out_data;

    logic [AW-1:0]   w_occ;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_ren;

    // A word waiting to commit still counts against space for the next completed word.
    assign w_occ      = {1'b0, r_word_count} + AW'(r_wr_pend);
    assign w_in_ready = !((r_byte_cnt == 2'd3) && (w_occ >= OCC_DEPTH));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_ren      = (r_word_count != '0) && !r_rd_inflight && !r_out_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_cnt <= '0;
            r_pack     <= '0;
            r_w_data   <= '0;
            r_wr_pend  <= 1'b0;
        end else begin
            r_wr_pend <= w_accept && (r_byte_cnt == 2'd3);
            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0:    r_pack[DW-1:0]      <= bus.in_data;
                    2'd1:    r_pack[2*DW-1:DW]   <= bus.in_data;
                    2'd2:    r_pack[3*DW-1:2*DW] <= bus.in_data;
                    default: r_w_data            <= {bus.in_data, r_pack};
                endcase
            end
        end
    end

    // Commit and read issue can coincide; their count effects then cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_word_count  <= '0;
            r_rd_inflight <= 1'b0;
        end else begin
            r_rd_inflight <= w_ren;
            if (r_wr_pend) r_wptr <= r_wptr + PTR_ONE;
            if (w_ren)     r_rptr <= r_rptr + PTR_ONE;
            case ({r_wr_pend, w_ren})
                2'b10:   r_word_count <= r_word_count + WC_ONE;
                2'b01:   r_word_count <= r_word_count - WC_ONE;
                default: r_word_count <= r_word_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (r_rd_inflight) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.ram_r_data;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.ram_wen    = r_wr_pend;
    assign bus.ram_w_addr = {r_wptr, 2'b00};
    assign bus.ram_w_data = r_w_data;
    assign bus.ram_ren    = w_ren;
    assign bus.ram_r_addr = {r_rptr, 2'b00};
    assign bus.word_count = r_word_count;
    assign bus.fifo_full  = (r_word_count == WC_DEPTH);
    assign bus.fifo_empty = (r_word_count == '0) && !r_wr_pend && !r_rd_inflight && !r_out_valid;
endmodule

// File: tb/tb_ram_byte_fifo_ctrl.sv
// Bench for ram_byte_fifo_ctrl: models dual_ram, checks every cycle against a queue-based
// reference, and runs a vector table plus directed reset/backpressure/wrap sequences.
module tb_ram_byte_fifo_ctrl;
    localparam int DW = 8, AW = 7, MEM_NUM = 128, DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_byte_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();
    ram_byte_fifo_ctrl #(.DW(DW), .AW(AW), .MEM_NUM(MEM_NUM)) dut (.clk(clk), .rst(rst), .bus(bus));

    // dual_ram stand-in: read data valid one cycle after ren
    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (bus.ram_wen) mem[bus.ram_w_addr[AW-1:2]] <= bus.ram_w_data;
        if (bus.ram_ren) bus.ram_r_data <= mem[bus.ram_r_addr[AW-1:2]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: bytes accepted, words completed, and rule-level occupancy bookkeeping.
    bit          mon_en = 0;
    int          m_bc, m_cnt, m_wen, m_infl, m_ov;
    int          wr_idx, rd_idx, out_idx;
    logic [31:0] m_cur;
    logic [31:0] words [$];

    function automatic logic [31:0] wexp(input int i);
        return (i < words.size()) ? words[i] : 32'hDEADBEEF;
    endfunction

    task automatic model_reset();
        m_bc = 0; m_cnt = 0; m_wen = 0; m_infl = 0; m_ov = 0;
        wr_idx = 0; rd_idx = 0; out_idx = 0; m_cur = '0;
        words.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            int e_rdy, e_ren, e_empty, acc, nxt_wen;
            e_rdy   = (m_bc == 3 && (m_cnt + m_wen) >= DEPTH) ? 0 : 1;
            e_ren   = (m_cnt > 0 && m_infl == 0 && m_ov == 0) ? 1 : 0;
            e_empty = (m_cnt == 0 && m_wen == 0 && m_infl == 0 && m_ov == 0) ? 1 : 0;
            chk("in_ready", 32'(bus.in_ready), e_rdy);
            chk("ram_wen", 32'(bus.ram_wen), m_wen);
            if (m_wen != 0 && bus.ram_wen) begin
                chk("ram_w_addr", 32'(bus.ram_w_addr), (wr_idx % DEPTH) * 4);
                chk("ram_w_data", bus.ram_w_data, wexp(wr_idx));
            end
            chk("ram_ren", 32'(bus.ram_ren), e_ren);
            if (e_ren != 0 && bus.ram_ren) chk("ram_r_addr", 32'(bus.ram_r_addr), (rd_idx % DEPTH) * 4);
            chk("word_count", 32'(bus.word_count), m_cnt);
            chk("fifo_full", 32'(bus.fifo_full), (m_cnt == DEPTH) ? 1 : 0);
            chk("fifo_empty", 32'(bus.fifo_empty), e_empty);
            chk("out_valid", 32'(bus.out_valid), m_ov);
            if (m_ov != 0) chk("out_data", bus.out_data, wexp(out_idx));

            acc     = (bus.in_valid && e_rdy != 0) ? 1 : 0;
            nxt_wen = 0;
            if (acc != 0) begin
                m_cur[m_bc*8 +: 8] = bus.in_data;
                if (m_bc == 3) begin
                    words.push_back(m_cur);
                    nxt_wen = 1;
                end
                m_bc = (m_bc + 1) % 4;
            end
            if (m_wen != 0) wr_idx++;
            if (e_ren != 0) rd_idx++;
            m_cnt = m_cnt + m_wen - e_ren;
            if (m_ov != 0 && bus.out_ready) begin
                m_ov = 0;
                out_idx++;
            end
            if (m_infl != 0) m_ov = 1;
            m_infl = e_ren;
            m_wen  = nxt_wen;
        end
    end

    // All drive tasks start and end at posedge+1.
    task automatic drive(input bit v, input logic [7:0] d, input bit ordy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit ordy);
        bit r;
        bit done;
        done = 0;
        drive(1'b1, d, ordy);
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            r = bus.in_ready;
            tick();
            if (r) done = 1;
        end
        if (!done) chk("send_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit ordy);
        drive(1'b0, 8'h00, ordy);
        repeat (n) tick();
    endtask

    task automatic drain();
        bit done;
        done = 0;
        drive(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (bus.fifo_empty) done = 1;
            tick();
        end
        chk("drain_empty", 32'(bus.fifo_empty), 32'd1);
    endtask

    typedef struct {
        bit          iv;
        logic [7:0]  d;
        bit          ordy;
        bit          e_rdy;
        bit          e_wen;
        logic [31:0] e_wdata;
        bit          e_ren;
        bit          e_ov;
        logic [31:0] e_odata;
        int          e_wc;
        bit          e_empty;
    } vec_t;

    vec_t tv [9];

    initial begin
        tv[0] = '{1, 8'h11, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 1};
        tv[1] = '{1, 8'h22, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 1};
        tv[2] = '{1, 8'h33, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 1};
        tv[3] = '{1, 8'h44, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 1};
        tv[4] = '{0, 8'h00, 1, 1, 1, 32'h44332211, 0, 0, 32'h0,        0, 0};
        tv[5] = '{0, 8'h00, 1, 1, 0, 32'h0,        1, 0, 32'h0,        1, 0};
        tv[6] = '{0, 8'h00, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 0};
        tv[7] = '{0, 8'h00, 1, 1, 0, 32'h0,        0, 1, 32'h44332211, 0, 0};
        tv[8] = '{0, 8'h00, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 1};

        // Reset held with a byte offered
        drive(1'b1, 8'h5A, 1'b0);
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ram_wen", 32'(bus.ram_wen), 32'd0);
        chk("rst_ram_ren", 32'(bus.ram_ren), 32'd0);
        chk("rst_fifo_empty", 32'(bus.fifo_empty), 32'd1);
        chk("rst_word_count", 32'(bus.word_count), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_w_addr", 32'(bus.ram_w_addr), 32'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        model_reset();
        mon_en = 1;

        // Single word, table-driven
        for (int i = 0; i < 9; i++) begin
            drive(tv[i].iv, tv[i].d, tv[i].ordy);
            @(negedge clk);
            chk($sformatf("tv%0d_in_ready", i), 32'(bus.in_ready), 32'(tv[i].e_rdy));
            chk($sformatf("tv%0d_ram_wen", i), 32'(bus.ram_wen), 32'(tv[i].e_wen));
            if (tv[i].e_wen) begin
                chk($sformatf("tv%0d_w_addr", i), 32'(bus.ram_w_addr), 32'd0);
                chk($sformatf("tv%0d_w_data", i), bus.ram_w_data, tv[i].e_wdata);
            end
            chk($sformatf("tv%0d_ram_ren", i), 32'(bus.ram_ren), 32'(tv[i].e_ren));
            chk($sformatf("tv%0d_out_valid", i), 32'(bus.out_valid), 32'(tv[i].e_ov));
            if (tv[i].e_ov) chk($sformatf("tv%0d_out_data", i), bus.out_data, tv[i].e_odata);
            chk($sformatf("tv%0d_word_count", i), 32'(bus.word_count), 32'(tv[i].e_wc));
            chk($sformatf("tv%0d_fifo_empty", i), 32'(bus.fifo_empty), 32'(tv[i].e_empty));
            tick();
        end

        // Fill with output stalled until the next completed word is refused
        for (int i = 0; i < 132; i++) send(8'(i), 1'b0);
        idle(4, 1'b0);
        chk("fill_full", 32'(bus.fifo_full), 32'd1);
        chk("fill_count", 32'(bus.word_count), 32'd32);
        chk("fill_out_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i), 1'b0);
        drive(1'b1, 8'hE3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fill_block", 32'(bus.in_ready), 32'd0);
            tick();
        end
        send(8'hE3, 1'b1);
        drain();

        // Continuous stream across the pointer wrap
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, 8'(i * 7 + 3), 1'b1);
            @(negedge clk);
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        bus.in_valid = 1'b0;
        drain();

        // Output backpressure hold
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1;
                tick();
            end
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_data", bus.out_data, 32'hA3A2A1A0);
            chk("hold_no_ren", 32'(bus.ram_ren), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1;
                if (!seen) tick();
            end
            chk("hold_next", bus.out_data, 32'hA7A6A5A4);
            tick();
        end
        drain();

        // Asynchronous reset mid-word with stored words
        for (int i = 0; i < 26; i++) send(8'h40 + 8'(i), 1'b0);
        idle(6, 1'b0);
        chk("pre_rst_count", 32'(bus.word_count), 32'd5);
        @(posedge clk);
        #3;
        mon_en = 0;
        rst = 1'b0;
        #1;
        chk("arst_ram_wen", 32'(bus.ram_wen), 32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data", bus.out_data, 32'd0);
        chk("arst_word_count", 32'(bus.word_count), 32'd0);
        chk("arst_fifo_empty", 32'(bus.fifo_empty), 32'd1);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        mon_en = 1;
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b1);
        send(8'hCC, 1'b1);
        send(8'hDD, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("post_rst_wen", 32'(bus.ram_wen), 32'd1);
        chk("post_rst_addr", 32'(bus.ram_w_addr), 32'd0);
        chk("post_rst_data", bus.ram_w_data, 32'hDDCCBBAA);
        tick();
        drain();

        // Randomized traffic against the reference
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0));
            tick();
        end
        drain();

        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
